iter_div_unit: RTL and testbench

//  Parametrised multi-cycle integer divider for the EXE stage. Supports signed and unsigned division.

---
 rtl/div_pkg.sv | 24 ++
 rtl/iter_div_unit_if.sv | 29 ++
 rtl/div_step.sv | 18 +
 rtl/iter_div_unit.sv | 146 ++++++++++++++
 tb/tb_iter_div_unit.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states, divide-by-zero quotient
// fill value and elaboration-time parameter helpers.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam logic [63:0] DZ_QUO = '1;

  function automatic bit bpc_legal(input int unsigned width, input int unsigned bpc);
    return ((bpc == 1) || (bpc == 2)) && (width % bpc == 0) &&
           (width >= 4) && (width % 2 == 0);
  endfunction

  // Iteration counter width; width/bpc is always >= 2 for legal parameters.
  function automatic int unsigned cnt_w(input int unsigned width, input int unsigned bpc);
    return $clog2(width / bpc);
  endfunction

endpackage

// File: rtl/iter_div_unit_if.sv
// Request/result handshake bundle of the iterative divider, including pipeline flush.
interface iter_div_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quo;
  logic [WIDTH-1:0] out_rem;
  logic             out_dz;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_signed, in_a, in_b, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_quo, out_rem, out_dz, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, in_tag, flush, out_ready,
    output in_ready, out_valid, out_quo, out_rem, out_dz, out_tag
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on a (WIDTH+1)-bit partial remainder.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   new_rem,
  output logic             q_bit
);
  logic [WIDTH+1:0] trial;

  always_comb begin
    trial   = {rem, next_bit} - {2'b00, divisor};
    q_bit   = ~trial[WIDTH+1];
    new_rem = q_bit ? trial[WIDTH:0] : {rem[WIDTH-1:0], next_bit};
  end
endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle signed/unsigned integer divider retiring BPC quotient bits per cycle,
// with valid/ready handshakes, flush, pass-through tag and divide-by-zero flagging.
module iter_div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1,
  parameter int unsigned TAG_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  iter_div_unit_if.slave bus
);
  localparam int unsigned      CNT_W    = cnt_w(WIDTH, BPC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH / BPC - 1);

  if (!bpc_legal(WIDTH, BPC)) begin : g_bad_param
    $error("iter_div_unit: illegal WIDTH/BPC combination");
  end

  div_state_e       state_q, state_d;
  logic             accept;
  logic             b_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] qa_q;
  logic [WIDTH-1:0] b_abs_q;
  logic             neg_quo_q, neg_rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] quo_o_q, rem_o_q;
  logic             dz_o_q;
  logic [TAG_W-1:0] tag_o_q;

  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] qa_nx;

  always_comb begin
    b_zero = (bus.in_b == '0);
    a_neg  = bus.in_signed & bus.in_a[WIDTH-1];
    b_neg  = bus.in_signed & bus.in_b[WIDTH-1];
    a_abs  = a_neg ? -bus.in_a : bus.in_a;
    b_abs  = b_neg ? -bus.in_b : bus.in_b;
  end

  // qa_q starts as |a|; each step consumes its MSB as the next dividend bit and
  // shifts the new quotient bit in at the LSB, so after WIDTH steps it holds the quotient.
  for (genvar i = 0; i < BPC; i++) begin : g_step
    logic [WIDTH:0]   rem_in, rem_out;
    logic [WIDTH-1:0] qa_in, qa_out;
    logic             q_bit;

    if (i == 0) begin : g_first
      assign rem_in = rem_q;
      assign qa_in  = qa_q;
    end else begin : g_chain
      assign rem_in = g_step[i-1].rem_out;
      assign qa_in  = g_step[i-1].qa_out;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_in),
      .next_bit (qa_in[WIDTH-1]),
      .divisor  (b_abs_q),
      .new_rem  (rem_out),
      .q_bit    (q_bit)
    );

    assign qa_out = {qa_in[WIDTH-2:0], q_bit};
  end

  assign rem_nx = g_step[BPC-1].rem_out;
  assign qa_nx  = g_step[BPC-1].qa_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = b_zero ? S_DONE : S_CALC;
        end
        S_CALC: if (cnt_q == CNT_LAST) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (bus.out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      qa_q      <= '0;
      b_abs_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      quo_o_q   <= '0;
      rem_o_q   <= '0;
      dz_o_q    <= 1'b0;
      tag_o_q   <= '0;
    end else begin
      if (accept) begin
        rem_q     <= '0;
        qa_q      <= a_abs;
        b_abs_q   <= b_abs;
        cnt_q     <= '0;
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        tag_o_q   <= bus.in_tag;
        dz_o_q    <= b_zero;
        if (b_zero) begin
          quo_o_q <= DZ_QUO[WIDTH-1:0];
          rem_o_q <= bus.in_a;
        end
      end
      if (state_q == S_CALC) begin
        rem_q <= rem_nx;
        qa_q  <= qa_nx;
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_FIX) begin
        quo_o_q <= neg_quo_q ? -qa_q : qa_q;
        rem_o_q <= neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      end
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_quo   = quo_o_q;
  assign bus.out_rem   = rem_o_q;
  assign bus.out_dz    = dz_o_q;
  assign bus.out_tag   = tag_o_q;
endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: directed corner cases on the BPC=1 unit and
// randomized operations on BPC=1 and BPC=2 units against an arithmetic reference model.
module tb_iter_div_unit;
  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          sel;
  logic          in_valid, in_signed, flush, out_ready;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag;
  logic          o_in_ready, o_valid, o_dz;
  logic [W-1:0]  o_quo, o_rem;
  logic [TW-1:0] o_tag;

  iter_div_unit_if #(.WIDTH(W), .TAG_W(TW)) bus1 ();
  iter_div_unit_if #(.WIDTH(W), .TAG_W(TW)) bus2 ();

  iter_div_unit #(.WIDTH(W), .BPC(1), .TAG_W(TW)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  iter_div_unit #(.WIDTH(W), .BPC(2), .TAG_W(TW)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus1.in_valid  = in_valid & ~sel;
  assign bus2.in_valid  = in_valid & sel;
  assign bus1.flush     = flush & ~sel;
  assign bus2.flush     = flush & sel;
  assign bus1.out_ready = out_ready & ~sel;
  assign bus2.out_ready = out_ready & sel;
  assign bus1.in_signed = in_signed;
  assign bus2.in_signed = in_signed;
  assign bus1.in_a      = in_a;
  assign bus2.in_a      = in_a;
  assign bus1.in_b      = in_b;
  assign bus2.in_b      = in_b;
  assign bus1.in_tag    = in_tag;
  assign bus2.in_tag    = in_tag;

  assign o_in_ready = sel ? bus2.in_ready  : bus1.in_ready;
  assign o_valid    = sel ? bus2.out_valid : bus1.out_valid;
  assign o_quo      = sel ? bus2.out_quo   : bus1.out_quo;
  assign o_rem      = sel ? bus2.out_rem   : bus1.out_rem;
  assign o_dz       = sel ? bus2.out_dz    : bus1.out_dz;
  assign o_tag      = sel ? bus2.out_tag   : bus1.out_tag;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {dz, quotient, remainder} straight from SV integer division semantics.
  function automatic logic [2*W:0] ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa, sb, sq, sr;
    logic [W-1:0] q, r;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[W-1:0];
      r  = sr[W-1:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat = rising edges after the accept edge before out_valid is seen.
  task automatic wait_valid(output int unsigned lat);
    lat = 0;
    while (!o_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    in_valid  = 1'b1;
    in_signed = sgn;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] tag,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int unsigned lat, exp_lat;
    // A divide-by-zero is in DONE right after the accept edge.
    exp_lat = edz ? 0 : (sel ? W / 2 + 1 : W + 1);
    check_eq({name, "_ready"}, o_in_ready, 1);
    issue(sgn, a, b, tag);
    wait_valid(lat);
    check_eq({name, "_lat"}, lat, exp_lat);
    check_eq({name, "_quo"}, o_quo, eq);
    check_eq({name, "_rem"}, o_rem, er);
    check_eq({name, "_dz"},  o_dz,  edz);
    check_eq({name, "_tag"}, o_tag, tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] min_v;
    min_v = '0;
    min_v[W-1] = 1'b1;
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 1;
      2:       return '1;
      3:       return min_v;
      4:       return W'($urandom_range(0, 255));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic random_run(input string name, input int unsigned count);
    logic          sgn;
    logic [W-1:0]  a, b;
    logic [TW-1:0] tag;
    logic [2*W:0]  e;
    for (int unsigned i = 0; i < count; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = pick_operand();
      b   = pick_operand();
      tag = TW'($urandom);
      e   = ref_div(sgn, a, b);
      run_op(name, sgn, a, b, tag, e[2*W-1:W], e[W-1:0], e[2*W]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held_quo;
    int unsigned  lat;

    sel = 1'b0; in_valid = 1'b0; in_signed = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    check_eq("rst_ready", o_in_ready, 1);
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_quo",   o_quo, 0);
    check_eq("rst_rem",   o_rem, 0);
    check_eq("rst_dz",    o_dz, 0);
    check_eq("rst_tag",   o_tag, 0);

    run_op("u100_7",   1'b0, 32'd100,        32'd7,        5'd4,  32'd14,        32'd2,        1'b0);
    run_op("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,        5'd5,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE, 5'd6, 32'hFFFF_FFFD, 32'd1,        1'b0);
    run_op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 32'd0,        1'b0);
    run_op("u_ovf",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8, 32'd0,         32'h8000_0000, 1'b0);
    run_op("dz",       1'b1, 32'h1234,       32'd0,        5'd17, 32'hFFFF_FFFF, 32'h1234,     1'b1);

    // Flush beats a same-cycle accept in IDLE.
    in_valid = 1'b1; in_b = '0; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check_eq("flush_idle_valid", o_valid, 0);
    check_eq("flush_idle_ready", o_in_ready, 1);

    // Flush ten cycles into CALC; the new request must finish with exact latency.
    issue(1'b0, 32'd1000, 32'd3, 5'd9);
    repeat (9) tick();
    flush = 1'b1;
    check_eq("flush_busy_ready", o_in_ready, 0);
    tick();
    flush = 1'b0;
    check_eq("flush_valid0", o_valid, 0);
    check_eq("flush_ready1", o_in_ready, 1);
    tick();
    check_eq("flush_valid1", o_valid, 0);
    run_op("post_flush", 1'b0, 32'd1000, 32'd7, 5'd21, 32'd142, 32'd6, 1'b0);

    // Back-pressure in DONE.
    issue(1'b1, 32'hFFFF_FF9C, 32'd9, 5'd3);
    wait_valid(lat);
    check_eq("stall_lat", lat, W + 1);
    held_quo = o_quo;
    check_eq("stall_quo", held_quo, 32'hFFFF_FFF5);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_valid", o_valid, 1);
      check_eq("stall_hold",  o_quo, held_quo);
      check_eq("stall_rem",   o_rem, 32'hFFFF_FFFF);
      check_eq("stall_ready", o_in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("release_ready", o_in_ready, 1);
    check_eq("release_valid", o_valid, 0);

    // Asynchronous reset mid-CALC.
    issue(1'b0, 32'hDEAD_BEEF, 32'h10, 5'h1F);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ready", o_in_ready, 1);
    check_eq("arst_valid", o_valid, 0);
    check_eq("arst_quo",   o_quo, 0);
    check_eq("arst_rem",   o_rem, 0);
    check_eq("arst_dz",    o_dz, 0);
    check_eq("arst_tag",   o_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    random_run("rnd_bpc1", 700);
    sel = 1'b1;
    tick();
    run_op("bpc2_u100_7", 1'b0, 32'd100, 32'd7, 5'd4, 32'd14, 32'd2, 1'b0);
    random_run("rnd_bpc2", 700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
